// File: rtl/store_buffer.sv
// Store buffer between the store unit and the data cache: FIFO of word-aligned
// byte-enabled stores with youngest-entry coalescing, load forwarding and flush.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int COALESCE   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic [ADDR_WIDTH-1:0]   push_address_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic [DATA_WIDTH/8-1:0] push_byte_en_i,
  output logic                    drain_valid_o,
  input  logic                    drain_ack_i,
  output logic [ADDR_WIDTH-1:0]   drain_address_o,
  output logic [DATA_WIDTH-1:0]   drain_data_o,
  output logic [DATA_WIDTH/8-1:0] drain_byte_en_o,
  input  logic [ADDR_WIDTH-1:0]   fwd_address_i,
  output logic                    fwd_hit_o,
  output logic [DATA_WIDTH-1:0]   fwd_data_o,
  output logic [DATA_WIDTH/8-1:0] fwd_byte_en_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int WA    = ADDR_WIDTH - OFF;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d, young;
  logic [CW-1:0]           count_q, count_d;
  logic [WA-1:0]           wa_q   [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [BYTES-1:0]        be_q   [DEPTH];
  logic [WA-1:0]           push_wa, fwd_wa;
  logic                    push_fire, pop, coalesce, alloc;

  assign push_wa = push_address_i[ADDR_WIDTH-1:OFF];
  assign fwd_wa  = fwd_address_i[ADDR_WIDTH-1:OFF];
  assign young   = tail_q - PW'(1);

  generate
    if (OFF > 0) begin : g_unused
      logic unused_offset;
      assign unused_offset = ^{push_address_i[OFF-1:0], fwd_address_i[OFF-1:0]};
    end
  endgenerate

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CW'(DEPTH));
  assign count_o       = count_q;
  assign drain_valid_o = !empty_o;
  assign drain_address_o = ADDR_WIDTH'(wa_q[head_q]) << OFF;
  assign drain_data_o    = data_q[head_q];
  assign drain_byte_en_o = be_q[head_q];

  assign push_fire = push_valid_i && push_ready_o;
  assign pop       = drain_valid_o && drain_ack_i;
  // A lone entry leaving this edge cannot absorb the push; it becomes a fresh entry.
  assign coalesce  = (COALESCE != 0) && push_fire && !empty_o && (push_wa == wa_q[young]) &&
                     !((count_q == CW'(1)) && pop);
  assign alloc     = push_fire && !coalesce;

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(alloc);
    count_d = count_q + CW'(alloc) - CW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      wa_q[tail_q]   <= push_wa;
      data_q[tail_q] <= push_data_i;
      be_q[tail_q]   <= push_byte_en_i;
    end else if (coalesce) begin
      for (int b = 0; b < BYTES; b++) begin
        if (push_byte_en_i[b]) data_q[young][b*8 +: 8] <= push_data_i[b*8 +: 8];
      end
      be_q[young] <= be_q[young] | push_byte_en_i;
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = '0;
    fwd_hit_o     = 1'b0;
    fwd_data_o    = '0;
    fwd_byte_en_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (wa_q[idx] == fwd_wa)) begin
        fwd_hit_o     = 1'b1;
        fwd_data_o    = data_q[idx];
        fwd_byte_en_o = be_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i) state_d = FLUSH;
      FLUSH:   if (empty_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_ready_o = !rst_i && !full_o && (state_q == IDLE);
    flush_done_o = (state_q == DONE);
  end
endmodule
